// File: rtl/tile_color_sched.sv
// tile_color_sched: walks a snapshot of the 4x4 board through the colour LUT and writes each colour out.
// Ports:
//   clk_i         rising-edge clock
//   rst_n_i       synchronous active-low reset
//   start_i       request a full board pass (sampled only while idle)
//   board_i       packed board, cell i = board_i[VAL_W*i +: VAL_W]
//   lut_value_o   cell value presented to the colour LUT
//   lut_color_i   combinational LUT colour for lut_value_o
//   wr_valid_o    write request valid
//   wr_ready_i    writer accepts when wr_valid_o && wr_ready_i
//   wr_addr_o     cell index of the pending write
//   wr_data_o     registered colour of the pending write
//   busy_o        pass in progress (LOOKUP/WRITE/DONE)
//   done_o        one-cycle pulse at the end of a pass
// Optional feature macro: CHANGED_ONLY_EN skips cells whose value matches the last value written.
module tile_color_sched #(
  parameter int N_CELLS = 16,
  parameter int VAL_W   = 4,
  parameter int COLOR_W = 24,
  parameter int ADDR_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [N_CELLS*VAL_W-1:0]   board_i,
  output logic [VAL_W-1:0]           lut_value_o,
  input  logic [COLOR_W-1:0]         lut_color_i,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [COLOR_W-1:0]         wr_data_o,
  output logic                       busy_o,
  output logic                       done_o
);
  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, DONE} state_t;
  state_t                     state_q;
  logic [ADDR_W-1:0]          idx_q;
  logic [N_CELLS*VAL_W-1:0]   snap_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic [COLOR_W-1:0]         wr_data_q;
  logic                       last;
  logic                       skip;
  assign last        = idx_q == ADDR_W'(N_CELLS - 1);
  assign lut_value_o = snap_q[idx_q*VAL_W +: VAL_W];
  assign wr_valid_o  = state_q == WRITE;
  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
`ifdef CHANGED_ONLY_EN
  logic [VAL_W-1:0] shadow_q [N_CELLS];
  logic [N_CELLS-1:0] shadow_v_q;
  // a cell is skipped only once it has been written with exactly this value
  assign skip = shadow_v_q[idx_q] && shadow_q[idx_q] == lut_value_o;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef CHANGED_ONLY_EN
      shadow_v_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          snap_q  <= board_i;
          idx_q   <= '0;
          state_q <= LOOKUP;
        end
        LOOKUP: if (skip) begin
          if (last) state_q <= DONE;
          else idx_q <= idx_q + 1'b1;
        end else begin
          wr_addr_q <= idx_q;
          wr_data_q <= lut_color_i;
          state_q   <= WRITE;
        end
        WRITE: if (wr_ready_i) begin
`ifdef CHANGED_ONLY_EN
          shadow_q[idx_q]   <= lut_value_o;
          shadow_v_q[idx_q] <= 1'b1;
`endif
          if (last) state_q <= DONE;
          else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= LOOKUP;
          end
        end
        DONE: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_color_sched.sv
// tb_tile_color_sched: table-driven and directed checks of the board colour scheduler.
module tb_tile_color_sched;
  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] board_i = '0;
  logic [3:0]  lut_value_o;
  logic [23:0] lut_color_i;
  logic        wr_valid_o;
  logic        wr_ready_i = 1'b1;
  logic [3:0]  wr_addr_o;
  logic [23:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  tile_color_sched dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .board_i(board_i),
    .lut_value_o(lut_value_o), .lut_color_i(lut_color_i), .wr_valid_o(wr_valid_o),
    .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [23:0] lut(input logic [3:0] v);
    case (v)
      4'd0:  lut = 24'hFFFF99;
      4'd3:  lut = 24'hFFCC99;
      4'd9:  lut = 24'hCC6666;
      4'd10: lut = 24'h993333;
      4'd11: lut = 24'hCCFFCC;
      4'd15: lut = 24'hDCDCDC;
      default: lut = {6{v}};
    endcase
  endfunction

  assign lut_color_i = lut(lut_value_o);

  typedef struct {
    logic [63:0] board;
    logic [63:0] mid;
    int          stall_cell;
    int          stall_n;
    int          s1;
    int          s2;
    int          exp_done;
    logic [23:0] exp_d0;
    logic [23:0] exp_d3;
  } vec_t;

  vec_t tab [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_i = 1'b0;
    start_i = 1'b0;
    wr_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  task automatic run_pass(input vec_t v);
    int nw, ndone, dcyc, stalled, exp_first;
    logic pend;
    logic [3:0] pa;
    logic [23:0] pd;
    logic [3:0] ra [32];
    logic [23:0] rd [32];
    int rf [32];
    do_reset();
    board_i = v.board;
    start_i = 1'b1;
    wr_ready_i = 1'b1;
    nw = 0; ndone = 0; dcyc = -1; stalled = 0; pend = 1'b0; pa = '0; pd = '0;
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      start_i = (t == v.s1) || (t == v.s2);
      if (t == 3) board_i = v.mid;
      if (done_o) begin
        ndone++;
        if (dcyc < 0) dcyc = t;
      end
      if (pend) begin
        chk("hold_valid", 32'(wr_valid_o), 1);
        chk("hold_addr", 32'(wr_addr_o), 32'(pa));
        chk("hold_data", 32'(wr_data_o), 32'(pd));
      end
      if (wr_valid_o && !pend && nw < 32) rf[nw] = t;
      wr_ready_i = !(wr_valid_o && int'(wr_addr_o) == v.stall_cell && stalled < v.stall_n);
      if (!wr_ready_i) stalled++;
      pend = wr_valid_o && !wr_ready_i;
      pa = wr_addr_o;
      pd = wr_data_o;
      if (wr_valid_o && wr_ready_i && nw < 32) begin
        ra[nw] = wr_addr_o;
        rd[nw] = wr_data_o;
        nw++;
      end
    end
    wr_ready_i = 1'b1;
    chk("write_count", 32'(nw), 16);
    for (int k = 0; k < 16 && k < nw; k++) begin
      exp_first = 2 + 2*k + ((k > v.stall_cell) ? v.stall_n : 0);
      chk($sformatf("addr[%0d]", k), 32'(ra[k]), 32'(k));
      chk($sformatf("data[%0d]", k), 32'(rd[k]), 32'(lut(v.board[4*k +: 4])));
      chk($sformatf("first_valid[%0d]", k), 32'(rf[k]), 32'(exp_first));
    end
    if (nw > 3) begin
      chk("data_cell0", 32'(rd[0]), 32'(v.exp_d0));
      chk("data_cell3", 32'(rd[3]), 32'(v.exp_d3));
    end
    chk("done_cycle", 32'(dcyc), 32'(v.exp_done));
    chk("done_pulses", 32'(ndone), 1);
    chk("busy_after", 32'(busy_o), 0);
  endtask

  initial begin
    tab[0] = '{64'h0, 64'h0, -1, 0, -1, -1, 33, 24'hFFFF99, 24'hFFFF99};
    tab[1] = '{64'h0000_0000_0000_FBA9, 64'h0000_0000_0000_FBA9, -1, 0, -1, -1, 33, 24'hCC6666, 24'hDCDCDC};
    tab[2] = '{64'h0, 64'h0, 5, 3, -1, -1, 36, 24'hFFFF99, 24'hFFFF99};
    tab[3] = '{64'h0, 64'h0, -1, 0, 4, 33, 33, 24'hFFFF99, 24'hFFFF99};
    tab[4] = '{64'h0000_0000_0000_3F3F, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, -1, -1, 33, 24'hDCDCDC, 24'hFFCC99};

    do_reset();
    chk("rst_valid", 32'(wr_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_addr", 32'(wr_addr_o), 0);
    chk("rst_data", 32'(wr_data_o), 0);
    chk("rst_lut", 32'(lut_value_o), 0);

    rst_n_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    chk("rst_wins_busy", 32'(busy_o), 0);
    rst_n_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("rst_wins_idle", 32'(busy_o), 0);

    for (int i = 0; i < 5; i++) run_pass(tab[i]);

    do_reset();
    board_i = 64'hFFFF_FFFF_FFFF_FFFF;
    start_i = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("midpass_valid_before", 32'(wr_valid_o), 1);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    chk("abort_valid", 32'(wr_valid_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_done", 32'(done_o), 0);
    chk("abort_addr", 32'(wr_addr_o), 0);
    chk("abort_data", 32'(wr_data_o), 0);
    chk("abort_lut", 32'(lut_value_o), 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(wr_valid_o || busy_o), 0);
    end
    run_pass(tab[0]);

`ifdef CHANGED_ONLY_EN
    begin
      int nw, dcyc;
      logic [3:0] a;
      logic [23:0] d;
      run_pass(tab[1]);
      board_i = tab[1].board;
      board_i[28 +: 4] = 4'd3;
      start_i = 1'b1;
      nw = 0; dcyc = -1; a = '0; d = '0;
      for (int t = 1; t <= 30; t++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (done_o && dcyc < 0) dcyc = t;
        if (wr_valid_o && wr_ready_i) begin
          nw++;
          a = wr_addr_o;
          d = wr_data_o;
        end
      end
      chk("co_writes", 32'(nw), 1);
      chk("co_addr", 32'(a), 7);
      chk("co_data", 32'(d), 32'h00FFCC99);
      chk("co_done", 32'(dcyc), 18);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
